// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: 25 MHz pixel enable from a 50 MHz clock, 800x525 scan,
// sync/blank decode and colour gating. Define VGA_OUT_REG_EN to register the DAC-side outputs.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       r_pix_en;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_frame_start;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_blank_n;
    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // pix_en is low on the first edge after reset, so the first advance lands on the second edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pix_en      <= 1'b0;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_frame_start <= r_pix_en & w_h_last & w_v_last;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_h_cnt <= 10'd0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    assign w_hs_n    = ~((r_h_cnt >= HS_START) && (r_h_cnt <= HS_END));
    assign w_vs_n    = ~((r_v_cnt >= VS_START) && (r_v_cnt <= VS_END));
    assign w_blank_n = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_r       = w_blank_n ? Red_in   : 8'h00;
    assign w_g       = w_blank_n ? Green_in : 8'h00;
    assign w_b       = w_blank_n ? Blue_in  : 8'h00;

`ifdef VGA_OUT_REG_EN
    logic [7:0] r_vga_r;
    logic [7:0] r_vga_g;
    logic [7:0] r_vga_b;
    logic       r_vga_hs;
    logic       r_vga_vs;
    logic       r_vga_blank_n;

    // Captured together on the pixel edge, so all DAC-side outputs trail DrawX/DrawY by one pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vga_r       <= 8'h00;
            r_vga_g       <= 8'h00;
            r_vga_b       <= 8'h00;
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_vga_blank_n <= 1'b0;
        end else if (r_pix_en) begin
            r_vga_r       <= w_r;
            r_vga_g       <= w_g;
            r_vga_b       <= w_b;
            r_vga_hs      <= w_hs_n;
            r_vga_vs      <= w_vs_n;
            r_vga_blank_n <= w_blank_n;
        end
    end

    assign VGA_R       = r_vga_r;
    assign VGA_G       = r_vga_g;
    assign VGA_B       = r_vga_b;
    assign VGA_HS      = r_vga_hs;
    assign VGA_VS      = r_vga_vs;
    assign VGA_BLANK_N = r_vga_blank_n;
`else
    assign VGA_R       = w_r;
    assign VGA_G       = w_g;
    assign VGA_B       = w_b;
    assign VGA_HS      = w_hs_n;
    assign VGA_VS      = w_vs_n;
    assign VGA_BLANK_N = w_blank_n;
`endif

    assign DrawX       = r_h_cnt;
    assign DrawY       = r_v_cnt;
    assign VGA_CLK     = r_pix_en;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a full-size instance for line timing and a shrunken instance
// for frame timing, both checked every cycle against a behavioural scan model.
module tb_vga_scan_gen;

`ifdef VGA_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } geo_t;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       hs, vs, bl;
  } col_t;

  typedef struct {
    int   h, v;
    logic pix, fs;
    col_t q;
  } mdl_t;

  typedef struct packed {
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic       hs, vs, bl, sy, ck, fs;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  typedef struct {
    int         x;
    logic [7:0] rgb;
    logic       hs, bl;
    logic [7:0] out;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       Clk;
  logic       Reset_n;
  logic [7:0] r_in, g_in, b_in;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic [9:0] dx_d, dy_d, dx_s, dy_s;
  logic [7:0] vr_d, vg_d, vb_d, vr_s, vg_s, vb_s;
  logic       ck_d, hs_d, vs_d, bl_d, sy_d, fs_d;
  logic       ck_s, hs_s, vs_s, bl_s, sy_s, fs_s;

  vga_scan_gen dut_d (
    .Clk(Clk), .Reset_n(Reset_n), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(dx_d), .DrawY(dy_d), .VGA_R(vr_d), .VGA_G(vg_d), .VGA_B(vb_d),
    .VGA_CLK(ck_d), .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK_N(bl_d),
    .VGA_SYNC_N(sy_d), .frame_start(fs_d)
  );

  vga_scan_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(dx_s), .DrawY(dy_s), .VGA_R(vr_s), .VGA_G(vg_s), .VGA_B(vb_s),
    .VGA_CLK(ck_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bl_s),
    .VGA_SYNC_N(sy_s), .frame_start(fs_s)
  );

  obs_t obs_d, obs_s;
  assign obs_d = {dx_d, dy_d, vr_d, vg_d, vb_d, hs_d, vs_d, bl_d, sy_d, ck_d, fs_d};
  assign obs_s = {dx_s, dy_s, vr_s, vg_s, vb_s, hs_s, vs_s, bl_s, sy_s, ck_s, fs_s};

  // ---------------- model ----------------
  geo_t gd, gs;
  mdl_t md, ms;

  function automatic col_t decode(int h, int v, geo_t g, logic [7:0] ri, logic [7:0] gi, logic [7:0] bi);
    col_t c;
    c.bl = (h < g.hv) && (v < g.vv);
    c.hs = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
    c.vs = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
    c.r  = c.bl ? ri : 8'h00;
    c.g  = c.bl ? gi : 8'h00;
    c.b  = c.bl ? bi : 8'h00;
    return c;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.h = 0; m.v = 0; m.pix = 1'b0; m.fs = 1'b0;
    m.q = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, bl: 1'b0};
    return m;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, geo_t g, logic [7:0] ri, logic [7:0] gi, logic [7:0] bi);
    mdl_t n = m;
    int   ht = g.hv + g.hf + g.hs + g.hb;
    int   vt = g.vv + g.vf + g.vs + g.vb;
    n.pix = ~m.pix;
    n.fs  = 1'b0;
    if (m.pix) begin
      n.q = decode(m.h, m.v, g, ri, gi, bi);
      if (m.h == ht - 1) begin
        n.h = 0;
        if (m.v == vt - 1) begin
          n.v  = 0;
          n.fs = 1'b1;
        end else begin
          n.v = m.v + 1;
        end
      end else begin
        n.h = m.h + 1;
      end
    end
    return n;
  endfunction

  function automatic obs_t expect_of(mdl_t m, geo_t g, logic [7:0] ri, logic [7:0] gi, logic [7:0] bi);
    obs_t o;
    col_t c;
`ifdef VGA_OUT_REG_EN
    c = m.q;
`else
    c = decode(m.h, m.v, g, ri, gi, bi);
`endif
    o.x = 10'(m.h); o.y = 10'(m.v);
    o.r = c.r; o.g = c.g; o.b = c.b;
    o.hs = c.hs; o.vs = c.vs; o.bl = c.bl;
    o.sy = 1'b0; o.ck = m.pix; o.fs = m.fs;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_obs(string name, obs_t got);
    obs_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got x=%0d y=%0d", name, got.x, got.y);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b sy=%b ck=%b fs=%b | want x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b sy=%b ck=%b fs=%b",
               name, $time, got.x, got.y, got.r, got.g, got.b, got.hs, got.vs, got.bl, got.sy, got.ck, got.fs,
               e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.bl, e.sy, e.ck, e.fs);
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- driver ----------------
  int         mode;     // 0 random colour, 1 fixed colour, 2 red follows the scan column
  logic [7:0] fix_rgb;
  int         cyc = 0;

  int hs_cnt, hs_start_x;
  logic hs_prev;
  int fs_n, fs_last, fs_period, fs_run, fs_wmax, vs_cnt, vs_low_last;

  task automatic push_and_check();
    exp_q.push_back(expect_of(md, gd, r_in, g_in, b_in));
    exp_q.push_back(expect_of(ms, gs, r_in, g_in, b_in));
    #1;
    check_obs("dflt", obs_d);
    check_obs("small", obs_s);
  endtask

  task automatic step();
    @(posedge Clk);
    md = mdl_next(md, gd, r_in, g_in, b_in);
    ms = mdl_next(ms, gs, r_in, g_in, b_in);
    @(negedge Clk);
    case (mode)
      1: begin r_in = fix_rgb; g_in = fix_rgb; b_in = fix_rgb; end
      2: begin r_in = md.h[7:0]; g_in = md.v[7:0]; b_in = 8'($urandom_range(0, 255)); end
      default: begin
        r_in = 8'($urandom_range(0, 255));
        g_in = 8'($urandom_range(0, 255));
        b_in = 8'($urandom_range(0, 255));
      end
    endcase
    push_and_check();
    cyc++;
    if (!obs_d.hs) begin
      if (hs_prev) hs_start_x = int'(obs_d.x);
      hs_cnt++;
    end
    hs_prev = obs_d.hs;
    if (!obs_s.vs) vs_cnt++;
    if (obs_s.fs) begin
      fs_run++;
      if (fs_run > fs_wmax) fs_wmax = fs_run;
      if (fs_run == 1) begin
        if (fs_n >= 1) begin
          fs_period   = cyc - fs_last;
          vs_low_last = vs_cnt;
        end
        fs_n++;
        fs_last = cyc;
        vs_cnt  = 0;
        chk("wrap_xy_zero", {obs_s.x, obs_s.y}, 32'd0);
      end
    end else begin
      fs_run = 0;
    end
    if (mode == 1 && obs_s.y == 10'd7 && obs_s.x == 10'd5)
      chk("small_vis_rgb", {obs_s.r, obs_s.g, obs_s.b}, {3{fix_rgb}});
    if (mode == 1 && obs_s.y == 10'd8 && obs_s.x == 10'(LAT))
      chk("small_y8_rgb", {obs_s.r, obs_s.g, obs_s.b}, 32'd0);
  endtask

  task automatic run_to(int tgt);
    int k = 0;
    while (!(md.h == tgt && md.pix == 1'b0) && k < 2000) begin
      step();
      k++;
    end
    if (!(md.h == tgt && md.pix == 1'b0)) begin
      n_vec++;
      n_bad++;
      $display("FAIL run_to: column %0d not reached in 2000 cycles (at %0d)", tgt, md.h);
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[9];

  initial begin
    gd = '{640, 16, 96, 48, 480, 10, 2, 33};
    gs = '{16, 4, 6, 4, 8, 2, 2, 3};
    // column, colour in, expected HS, expected BLANK_N, expected colour out (line 0)
    tbl[0] = '{100, 8'h5A, 1'b1, 1'b1, 8'h5A};
    tbl[1] = '{639, 8'hFF, 1'b1, 1'b1, 8'hFF};
    tbl[2] = '{640, 8'hFF, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{655, 8'hC3, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{656, 8'hC3, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{700, 8'h11, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{751, 8'h11, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{752, 8'h77, 1'b1, 1'b0, 8'h00};
    tbl[8] = '{798, 8'h77, 1'b1, 1'b0, 8'h00};

    Reset_n = 1'b0;
    r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
    mode = 0; fix_rgb = 8'h00;
    md = mdl_reset(); ms = mdl_reset();
    hs_cnt = 0; hs_start_x = -1; hs_prev = 1'b1;
    fs_n = 0; fs_last = 0; fs_period = 0; fs_run = 0; fs_wmax = 0; vs_cnt = 0; vs_low_last = 0;

    repeat (3) @(negedge Clk);
    push_and_check();
    chk("rst_hs_vs", {hs_d, vs_d}, 32'd3);
    chk("rst_fs", fs_d, 32'd0);

    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    chk("rel_edge1_x", dx_d, 32'd0);
    step();
    chk("rel_edge2_x", dx_d, 32'd1);

    // Line 0 of the full-size instance, sampled at the table's columns.
    mode = 1;
    hs_cnt = 0; hs_prev = 1'b1; hs_start_x = -1;
    for (int i = 0; i < 9; i++) begin
      fix_rgb = tbl[i].rgb;
      run_to(tbl[i].x + LAT);
      chk($sformatf("tbl%0d_hs", i), hs_d, tbl[i].hs);
      chk($sformatf("tbl%0d_bl", i), bl_d, tbl[i].bl);
      chk($sformatf("tbl%0d_rgb", i), {vr_d, vg_d, vb_d}, {3{tbl[i].out}});
    end
    chk("hs_low_clks", hs_cnt, 32'd192);
    chk("hs_start_x", hs_start_x, 32'(656 + LAT));

    // Frame timing on the shrunken instance: 30x15 pixels, 900 Clk per frame.
    fix_rgb = 8'hFF;
    fs_n = 0; fs_run = 0; fs_wmax = 0; vs_cnt = 0; fs_period = 0; vs_low_last = 0;
    repeat (2800) step();
    chk("fs_pulses_ge3", (fs_n >= 3), 32'd1);
    chk("fs_period", fs_period, 32'd900);
    chk("fs_width", fs_wmax, 32'd1);
    chk("vs_low_clks", vs_low_last, 32'd120);

    mode = 2;
    repeat (300) step();

    // Abandon the frame mid-line at column 300.
    mode = 0;
    run_to(300);
    #2;
    Reset_n = 1'b0;
    md = mdl_reset(); ms = mdl_reset();
    exp_q.push_back(expect_of(md, gd, r_in, g_in, b_in));
    exp_q.push_back(expect_of(ms, gs, r_in, g_in, b_in));
    #1;
    check_obs("mid_rst_dflt", obs_d);
    check_obs("mid_rst_small", obs_s);
    chk("mid_rst_xy", {dx_d, dy_d}, 32'd0);
    chk("mid_rst_syncs", {hs_d, vs_d}, 32'd3);
    chk("mid_rst_fs", fs_d, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    step();
    chk("mid_rel_x", dx_d, 32'd1);
    chk("mid_rel_y", dy_d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch/sync widths in pixels (line total 800).
REQ-003 SHALL have parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines (frame total 525).
REQ-004 SHALL have port Clk, input, 1, 50 MHz system clock; all state on rising edge.
REQ-005 SHALL have port Reset_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ports Red_in, Green_in, Blue_in, input, 8 each: pixel colour from the colour mapper for the current DrawX/DrawY.
REQ-007 SHALL have ports DrawX, DrawY, output, 10 each: current horizontal/vertical scan counters.
REQ-008 SHALL have ports VGA_R, VGA_G, VGA_B, output, 8 each: DAC colour.
REQ-009 SHALL have ports VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, output, 1 each: pixel clock, active-low syncs, active-low blank, composite sync.
REQ-010 SHALL have port frame_start, output, 1: one-Clk pulse at frame wrap.

Function
REQ-011 SHALL generate internal pix_en toggling every Clk (25 MHz rate); VGA_CLK SHALL equal the pix_en register.
REQ-012 SHALL advance h_cnt only on Clk edges with pix_en=1; h_cnt wraps 799 -> 0.
REQ-013 SHALL advance v_cnt only when pix_en=1 and h_cnt=799; v_cnt wraps 524 -> 0; simultaneous h/v wrap goes to (0,0).
REQ-014 SHALL drive DrawX=h_cnt, DrawY=v_cnt directly (no offset, 10-bit unsigned).
REQ-015 SHALL assert VGA_HS low for h_cnt in [656,751] inclusive (H_VISIBLE+H_FRONT to +H_SYNC-1), high otherwise.
REQ-016 SHALL assert VGA_VS low for v_cnt in [490,491] inclusive, high otherwise.
REQ-017 SHALL drive blank_n=1 iff h_cnt<640 and v_cnt<480.
REQ-018 SHALL force VGA_R/G/B to 0 whenever blank_n=0, else pass Red_in/Green_in/Blue_in.
REQ-019 SHALL tie VGA_SYNC_N to 0.
REQ-020 SHALL pulse frame_start for exactly one Clk on the edge where pix_en=1, h_cnt=799, v_cnt=524.
REQ-021 SHALL produce exactly 840000 Clk cycles between consecutive frame_start pulses.

Reset
REQ-022 SHALL on Reset_n=0 immediately set h_cnt=0, v_cnt=0, pix_en=0, frame_start=0, pipeline registers 0, VGA_HS=1, VGA_VS=1.
REQ-023 SHALL after Reset_n release make the first counter advance on the second Clk rising edge.
REQ-024 SHALL on reset mid-frame abandon the frame; scan restarts at (0,0) with no frame_start pulse.

Configuration
REQ-025 SHALL honour macro VGA_OUT_REG_EN.
REQ-026 With VGA_OUT_REG_EN defined: VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N SHALL be registered on pix_en edges, delayed one pixel relative to DrawX/DrawY, all mutually aligned.
REQ-027 Without VGA_OUT_REG_EN: those outputs SHALL be combinational decodes of current h_cnt/v_cnt and inputs, zero-pixel latency.

Verification
REQ-028 Reset asserted mid-line at (300,100) -> DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, frame_start=0 same cycle; release -> DrawX=1 after 2nd Clk edge.
REQ-029 Free-run one line -> VGA_HS low for exactly 192 Clk cycles starting when DrawX=656 (macro off) / 657 (macro on).
REQ-030 Free-run two frames -> frame_start pulses 840000 Clk apart, each 1 Clk wide; VGA_VS low exactly 3200 Clk per frame.
REQ-031 Red_in=Green_in=Blue_in=8'hFF constant -> VGA RGB=FF only while DrawX<640 and DrawY<480, 00 at DrawX=640 and DrawY=480.
REQ-032 Macro on, Red_in=DrawX[7:0] -> VGA_R equals DrawX[7:0] of the previous pixel, blank/syncs shifted identically.
REQ-033 Count frame at v_cnt=524 wrap -> DrawY returns to 0 on same pix_en edge as DrawX 799->0.
